layer_sched: RTL and testbench
==============================

LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18, DRAM address width.
REQ-002 SHALL have parameter NUM_LAYERS, default 3, layers per run, legal range 1..8.
REQ-003 SHALL have parameter LAYER_TYPES, default 16'h0024, 16 bits; entry i at bits [2i+1:2i]; 0=conv, 1=pool, 2=fc, 3=illegal.
REQ-004 SHALL have ports: clk input 1 (sole clock); rst input 1 (asynchronous, active-high reset).
REQ-005 SHALL have ports: start input 1 (run request); busy output 1; done output 1 (one-cycle pulse); err output 1; layer_idx output 3; cycle_cnt output 16.
REQ-006 SHALL have per-engine ports, with X in {conv, pool, fc}: X_en output 1; X_done input 1; X_dram_valid output 1; X_en_rd input 1; X_en_wr input 1; X_addr_in input ADDR_WIDTH; X_addr_out input ADDR_WIDTH.
REQ-007 SHALL have shared DRAM ports: dram_valid input 1; dram_en_rd output 1; dram_en_wr output 1; addr_in output ADDR_WIDTH; addr_out output ADDR_WIDTH.

Function
REQ-008 SHALL implement FSM states IDLE, LAUNCH, RUN, NEXT, FIN, ERR, with all state and outputs registered.
REQ-009 IDLE: start=1 SHALL clear layer_idx and cycle_cnt and go to LAUNCH next cycle; busy=0 in IDLE.
REQ-010 LAUNCH (1 cycle): decode type = LAYER_TYPES entry layer_idx; type 3 SHALL go to ERR; else SHALL go to RUN.
REQ-011 RUN: exactly the selected engine's X_en SHALL be 1 for every RUN cycle, with the other two X_en 0.
REQ-012 RUN: selected engine's X_done=1 SHALL cause transition to NEXT; X_en goes 0 the following cycle.
REQ-013 NEXT (1 cycle, all X_en=0): layer_idx==NUM_LAYERS-1 SHALL go to FIN; else SHALL increment layer_idx and go to LAUNCH.
REQ-014 FIN: done=1 for exactly one cycle, then SHALL go to IDLE; layer_idx holds its last value.
REQ-015 ERR: err=1 and busy=0, all X_en=0; SHALL be sticky until rst.
REQ-016 busy SHALL be 1 in LAUNCH, RUN, NEXT and FIN.
REQ-017 Mux, in RUN only: dram_en_rd, dram_en_wr, addr_in and addr_out SHALL equal the selected engine's inputs combinationally.
REQ-018 Mux, in RUN only: dram_valid SHALL route to the selected X_dram_valid only.
REQ-019 Mux, outside RUN: all shared DRAM outputs and all X_dram_valid SHALL be 0.
REQ-020 cycle_cnt SHALL increment by 1 per RUN cycle, including the done cycle, saturate at 16'hFFFF, and hold its value in IDLE/FIN/ERR until the next accepted start.
REQ-021 Boundary: start while busy=1 or in ERR SHALL be ignored.
REQ-022 Boundary: X_done from a non-selected engine, or any X_done outside RUN, SHALL be ignored.
REQ-023 Boundary: start and X_done asserted in the same cycle SHALL be handled by state only (per REQ-009/REQ-012); neither implies the other.
REQ-024 Boundary: NUM_LAYERS=1 SHALL go LAUNCH -> RUN -> NEXT -> FIN without incrementing layer_idx.
REQ-025 Engine DRAM requests (X_en_rd/X_en_wr) presented while that engine is not selected SHALL NOT reach the shared port.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE and busy, done, err, all X_en, dram_en_rd, dram_en_wr, addr_in, addr_out, all X_dram_valid = 0, layer_idx=0, cycle_cnt=0.
REQ-027 rst asserted mid-RUN SHALL drop X_en and the shared DRAM enables in the same cycle without waiting for a clock edge; after rst release, no layer SHALL resume without a new start.

Verification
REQ-028 Bench: default params, start pulse, each engine raises X_done on its 5th RUN cycle -> en order conv, pool, fc, each with one NEXT gap; done pulses once; cycle_cnt=15; layer_idx=2.
REQ-029 Bench: during pool RUN, drive conv_en_rd=1 conv_addr_in=0x100 and pool_en_rd=1 pool_addr_in=0x2A5 -> dram_en_rd=1, addr_in=0x2A5; dram_valid=1 appears only on pool_dram_valid.
REQ-030 Bench: LAYER_TYPES=16'h000C, NUM_LAYERS=2 -> conv layer completes, LAUNCH of layer 1 enters ERR; err=1 sticky; start ignored; no X_en asserted.
REQ-031 Bench: rst asserted on the 3rd cycle of conv RUN -> conv_en=0 and dram_en_rd/dram_en_wr=0 before the next edge; after release, stays IDLE with cycle_cnt=0.
REQ-032 Bench: start re-pulsed during RUN, plus a fc_done pulse during conv RUN -> no restart, no state change; run completes normally with done once.
REQ-033 Bench: NUM_LAYERS=1, conv_done held low 70000 cycles -> cycle_cnt saturates at 16'hFFFF; conv_done then -> FIN, done pulse.

Source files
------------

// File: rtl/layer_sched.sv
// -----------------------------------------------------------------------------
// layer_sched
// Steps a network of NUM_LAYERS layers through three compute engines
// (conv, pool, fc). Each layer's engine type is taken from LAYER_TYPES.
// One engine at a time gets the shared DRAM port. An illegal layer type parks
// the scheduler in a sticky error state that only rst clears.
//
// Ports
//   clk, rst            sole clock; asynchronous active-high reset
//   start               run request, accepted only in IDLE
//   busy, done, err     status (done is a one-cycle pulse at the end of a run)
//   layer_idx           index of the layer being scheduled
//   cycle_cnt           RUN cycles in the current or last run (saturating)
//   X_en / X_done       per-engine enable and completion (X = conv/pool/fc)
//   X_en_rd, X_en_wr,
//   X_addr_in/out       per-engine DRAM request, muxed onto the shared port
//   X_dram_valid        shared dram_valid routed back to the selected engine
//   dram_*, addr_*      shared DRAM port
// -----------------------------------------------------------------------------
module layer_sched #(
    parameter int          ADDR_WIDTH  = 18,
    parameter int          NUM_LAYERS  = 3,
    parameter logic [15:0] LAYER_TYPES = 16'h0024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            layer_idx,
    output logic [15:0]           cycle_cnt,
    output logic                  conv_en,
    input  logic                  conv_done,
    output logic                  conv_dram_valid,
    input  logic                  conv_en_rd,
    input  logic                  conv_en_wr,
    input  logic [ADDR_WIDTH-1:0] conv_addr_in,
    input  logic [ADDR_WIDTH-1:0] conv_addr_out,
    output logic                  pool_en,
    input  logic                  pool_done,
    output logic                  pool_dram_valid,
    input  logic                  pool_en_rd,
    input  logic                  pool_en_wr,
    input  logic [ADDR_WIDTH-1:0] pool_addr_in,
    input  logic [ADDR_WIDTH-1:0] pool_addr_out,
    output logic                  fc_en,
    input  logic                  fc_done,
    output logic                  fc_dram_valid,
    input  logic                  fc_en_rd,
    input  logic                  fc_en_wr,
    input  logic [ADDR_WIDTH-1:0] fc_addr_in,
    input  logic [ADDR_WIDTH-1:0] fc_addr_out,
    input  logic                  dram_valid,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_FIN, S_ERR
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_LAYERS - 1);

    state_t      state_q, state_d;
    logic [2:0]  layer_idx_q, layer_idx_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Engine-indexed views of the per-engine ports. Slot 3 stands for the
    // illegal type and is tied off so a 2-bit select never indexes past the end.
    logic [3:0]            eng_done, eng_rd, eng_wr;
    logic [ADDR_WIDTH-1:0] eng_ain [4];
    logic [ADDR_WIDTH-1:0] eng_aout[4];
    logic [2:0]            eng_dv;

    logic [1:0] cur_type;
    logic       run_active;
    logic       sel_done;

    assign eng_done = {1'b0, fc_done, pool_done, conv_done};
    assign eng_rd   = {1'b0, fc_en_rd, pool_en_rd, conv_en_rd};
    assign eng_wr   = {1'b0, fc_en_wr, pool_en_wr, conv_en_wr};
    assign eng_ain[0]  = conv_addr_in;
    assign eng_ain[1]  = pool_addr_in;
    assign eng_ain[2]  = fc_addr_in;
    assign eng_ain[3]  = '0;
    assign eng_aout[0] = conv_addr_out;
    assign eng_aout[1] = pool_addr_out;
    assign eng_aout[2] = fc_addr_out;
    assign eng_aout[3] = '0;

    assign cur_type   = LAYER_TYPES[{layer_idx_q, 1'b0} +: 2];
    assign run_active = (state_q == S_RUN);
    // Only the engine that owns the current layer can end it.
    assign sel_done   = run_active && eng_done[sel_q];

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        cycle_cnt_d = cycle_cnt_q;
        sel_d       = sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    layer_idx_d = '0;
                    cycle_cnt_d = '0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                sel_d   = cur_type;
                state_d = (cur_type == 2'd3) ? S_ERR : S_RUN;
            end
            S_RUN: begin
                if (cycle_cnt_q != 16'hFFFF) begin
                    cycle_cnt_d = cycle_cnt_q + 16'd1;
                end
                if (sel_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (layer_idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    layer_idx_d = layer_idx_q + 3'd1;
                    state_d     = S_LAUNCH;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Status and enables are computed from the next state so that the
        // registered copies line up exactly with the state they describe.
        en_d = 3'b000;
        if (state_d == S_RUN) begin
            case (sel_d)
                2'd0:    en_d = 3'b001;
                2'd1:    en_d = 3'b010;
                2'd2:    en_d = 3'b100;
                default: en_d = 3'b000;
            endcase
        end
        busy_d = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                 (state_d == S_NEXT)   || (state_d == S_FIN);
        done_d = (state_d == S_FIN);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            cycle_cnt_q <= '0;
            sel_q       <= '0;
            en_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Shared DRAM mux: open only in RUN and only for the selected engine.
    // Gating on the registered state means rst closes it with no clock edge.
    always_comb begin
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        if (run_active) begin
            dram_en_rd = eng_rd[sel_q];
            dram_en_wr = eng_wr[sel_q];
            addr_in    = eng_ain[sel_q];
            addr_out   = eng_aout[sel_q];
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_dv
        assign eng_dv[gi] = run_active && en_q[gi] && dram_valid;
    end

    assign conv_dram_valid = eng_dv[0];
    assign pool_dram_valid = eng_dv[1];
    assign fc_dram_valid   = eng_dv[2];

    assign conv_en   = en_q[0];
    assign pool_en   = en_q[1];
    assign fc_en     = en_q[2];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign layer_idx = layer_idx_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_layer_sched
// Three schedulers side by side:
//   u0: default parameters (conv, pool, fc)
//   u1: LAYER_TYPES=16'h000C, NUM_LAYERS=2 (conv, then illegal)
//   u2: NUM_LAYERS=1 (single conv layer)
// The reference model is a per-run timeline: start, then for each layer
// LAUNCH, L RUN cycles, NEXT, and finally FIN. Expected outputs for every
// cycle come from that timeline and from the routing rules of the shared port.
// -----------------------------------------------------------------------------
module tb_layer_sched;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a[3], start_a[3];
    logic          busy_a[3], done_a[3], err_a[3];
    logic [2:0]    lidx_a[3];
    logic [15:0]   cnt_a[3];
    logic [2:0]    xdone_a[3], xrd_a[3], xwr_a[3];
    logic [AW-1:0] xain_a[3][3], xaout_a[3][3];
    logic          cen_a[3], pen_a[3], fen_a[3];
    logic          cdv_a[3], pdv_a[3], fdv_a[3];
    logic [2:0]    xen_a[3], xdv_a[3];
    logic          dv_a[3], drd_a[3], dwr_a[3];
    logic [AW-1:0] ain_a[3], aout_a[3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        layer_sched #(
            .ADDR_WIDTH (AW),
            .NUM_LAYERS ((gi == 0) ? 3 : ((gi == 1) ? 2 : 1)),
            .LAYER_TYPES((gi == 1) ? 16'h000C : 16'h0024)
        ) u_dut (
            .clk            (clk),
            .rst            (rst_a[gi]),
            .start          (start_a[gi]),
            .busy           (busy_a[gi]),
            .done           (done_a[gi]),
            .err            (err_a[gi]),
            .layer_idx      (lidx_a[gi]),
            .cycle_cnt      (cnt_a[gi]),
            .conv_en        (cen_a[gi]),
            .conv_done      (xdone_a[gi][0]),
            .conv_dram_valid(cdv_a[gi]),
            .conv_en_rd     (xrd_a[gi][0]),
            .conv_en_wr     (xwr_a[gi][0]),
            .conv_addr_in   (xain_a[gi][0]),
            .conv_addr_out  (xaout_a[gi][0]),
            .pool_en        (pen_a[gi]),
            .pool_done      (xdone_a[gi][1]),
            .pool_dram_valid(pdv_a[gi]),
            .pool_en_rd     (xrd_a[gi][1]),
            .pool_en_wr     (xwr_a[gi][1]),
            .pool_addr_in   (xain_a[gi][1]),
            .pool_addr_out  (xaout_a[gi][1]),
            .fc_en          (fen_a[gi]),
            .fc_done        (xdone_a[gi][2]),
            .fc_dram_valid  (fdv_a[gi]),
            .fc_en_rd       (xrd_a[gi][2]),
            .fc_en_wr       (xwr_a[gi][2]),
            .fc_addr_in     (xain_a[gi][2]),
            .fc_addr_out    (xaout_a[gi][2]),
            .dram_valid     (dv_a[gi]),
            .dram_en_rd     (drd_a[gi]),
            .dram_en_wr     (dwr_a[gi]),
            .addr_in        (ain_a[gi]),
            .addr_out       (aout_a[gi])
        );
        assign xen_a[gi] = {fen_a[gi], pen_a[gi], cen_a[gi]};
        assign xdv_a[gi] = {fdv_a[gi], pdv_a[gi], cdv_a[gi]};
    end

    int n_checks = 0;
    int n_errs   = 0;
    int done_seen;
    bit noise_en = 1'b0;
    bit dir29    = 1'b0;
    int lens[8];

    // model state carried between runs, per instance
    logic [2:0]  m_lidx[3];
    logic [15:0] m_cnt[3];
    bit          m_err[3];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Layer type table as configured on each instance: 0 conv, 1 pool, 2 fc, 3 illegal
    function automatic logic [1:0] ltype(input int inst, input int k);
        if (inst == 0) return 2'(k);
        if (inst == 1 && k == 1) return 2'd3;
        return 2'd0;
    endfunction

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic cyc(input int inst, input bit e_busy, input bit e_done, input bit e_err,
                       input logic [2:0] e_en, input logic [2:0] e_lidx,
                       input logic [15:0] e_cnt, input bit fire, input bit go);
        logic [2:0] nd;
        int s;
        @(posedge clk);
        #1;
        nd = noise_en ? 3'($urandom) : 3'b000;
        xdone_a[inst] = (fire ? e_en : 3'b000) | (nd & ~e_en);
        start_a[inst] = go | (noise_en && (e_busy || e_err) && ($urandom_range(0, 1) == 1));
        if (dir29) begin
            xrd_a[inst] = 3'b011;
            xwr_a[inst] = 3'b000;
            xain_a[inst][0] = 18'h100;
            xain_a[inst][1] = 18'h2A5;
            xain_a[inst][2] = '0;
            for (int e = 0; e < 3; e++) xaout_a[inst][e] = '0;
            dv_a[inst] = 1'b1;
        end else if (noise_en) begin
            xrd_a[inst] = 3'($urandom);
            xwr_a[inst] = 3'($urandom);
            for (int e = 0; e < 3; e++) begin
                xain_a[inst][e]  = AW'($urandom);
                xaout_a[inst][e] = AW'($urandom);
            end
            dv_a[inst] = 1'($urandom);
        end else begin
            xrd_a[inst] = '0;
            xwr_a[inst] = '0;
            for (int e = 0; e < 3; e++) begin
                xain_a[inst][e]  = '0;
                xaout_a[inst][e] = '0;
            end
            dv_a[inst] = 1'b0;
        end
        @(negedge clk);
        chk_eq("busy", busy_a[inst], e_busy);
        chk_eq("done", done_a[inst], e_done);
        chk_eq("err", err_a[inst], e_err);
        chk_eq("x_en", xen_a[inst], e_en);
        chk_eq("layer_idx", lidx_a[inst], e_lidx);
        chk_eq("cycle_cnt", cnt_a[inst], e_cnt);
        if (e_en != 3'b000) begin
            s = (e_en == 3'b010) ? 1 : ((e_en == 3'b100) ? 2 : 0);
            chk_eq("dram_en_rd", drd_a[inst], xrd_a[inst][s]);
            chk_eq("dram_en_wr", dwr_a[inst], xwr_a[inst][s]);
            chk_eq("addr_in", ain_a[inst], xain_a[inst][s]);
            chk_eq("addr_out", aout_a[inst], xaout_a[inst][s]);
            chk_eq("x_dram_valid", xdv_a[inst], dv_a[inst] ? e_en : 3'b000);
        end else begin
            chk_eq("dram_en_rd_off", drd_a[inst], 0);
            chk_eq("dram_en_wr_off", dwr_a[inst], 0);
            chk_eq("addr_in_off", ain_a[inst], 0);
            chk_eq("addr_out_off", aout_a[inst], 0);
            chk_eq("x_dram_valid_off", xdv_a[inst], 0);
        end
        if (done_a[inst]) done_seen++;
    endtask

    // Idle (or error) cycles; in the error state start is held high to prove it is ignored.
    task automatic idle(input int inst, input int n);
        for (int i = 0; i < n; i++)
            cyc(inst, 1'b0, 1'b0, m_err[inst], 3'b000, m_lidx[inst], m_cnt[inst], 1'b0, m_err[inst]);
    endtask

    // Full run from IDLE using lens[] as the RUN length of each layer.
    task automatic run_layers(input int inst, input int nl);
        int cnt;
        logic [1:0] t;
        cnt = 0;
        done_seen = 0;
        cyc(inst, 1'b0, 1'b0, 1'b0, 3'b000, m_lidx[inst], m_cnt[inst], 1'b0, 1'b1);
        for (int k = 0; k < nl; k++) begin
            t = ltype(inst, k);
            cyc(inst, 1'b1, 1'b0, 1'b0, 3'b000, 3'(k), 16'(cnt), 1'b0, 1'b0);
            if (t == 2'd3) begin
                m_lidx[inst] = 3'(k);
                m_cnt[inst]  = 16'(cnt);
                m_err[inst]  = 1'b1;
                $display("run inst=%0d layer=%0d illegal type, expecting sticky error", inst, k);
                return;
            end
            for (int j = 1; j <= lens[k]; j++) begin
                cyc(inst, 1'b1, 1'b0, 1'b0, 3'b001 << t, 3'(k), 16'(cnt), (j == lens[k]), 1'b0);
                if (cnt < 65535) cnt++;
            end
            cyc(inst, 1'b1, 1'b0, 1'b0, 3'b000, 3'(k), 16'(cnt), 1'b0, 1'b0);
        end
        cyc(inst, 1'b1, 1'b1, 1'b0, 3'b000, 3'(nl - 1), 16'(cnt), 1'b0, 1'b0);
        m_lidx[inst] = 3'(nl - 1);
        m_cnt[inst]  = 16'(cnt);
        cyc(inst, 1'b0, 1'b0, 1'b0, 3'b000, m_lidx[inst], m_cnt[inst], 1'b0, 1'b0);
        chk_eq("done_pulses", done_seen, 1);
        $display("run inst=%0d layers=%0d cycle_cnt=%0d layer_idx=%0d", inst, nl, cnt, nl - 1);
    endtask

    // Reset on the 3rd conv RUN cycle: enables must drop before the next edge.
    task automatic rst_mid();
        cyc(0, 1'b0, 1'b0, 1'b0, 3'b000, m_lidx[0], m_cnt[0], 1'b0, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd0, 16'd0, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0, 3'b001, 3'd0, 16'd0, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b0, 3'b001, 3'd0, 16'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        xrd_a[0] = 3'b111;
        xwr_a[0] = 3'b111;
        #1;
        chk_eq("pre_rst_conv_en", xen_a[0], 3'b001);
        chk_eq("pre_rst_dram_rd", drd_a[0], 1);
        rst_a[0] = 1'b1;
        #1;
        chk_eq("rst_x_en", xen_a[0], 0);
        chk_eq("rst_dram_rd", drd_a[0], 0);
        chk_eq("rst_dram_wr", dwr_a[0], 0);
        chk_eq("rst_busy", busy_a[0], 0);
        chk_eq("rst_cnt", cnt_a[0], 0);
        @(posedge clk);
        #1;
        rst_a[0] = 1'b0;
        xrd_a[0] = '0;
        xwr_a[0] = '0;
        m_lidx[0] = '0;
        m_cnt[0]  = '0;
        m_err[0]  = 1'b0;
        idle(0, 5);
        $display("async reset mid-run checked on inst 0");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1;
            start_a[i] = 1'b0;
            xdone_a[i] = '0;
            xrd_a[i] = '0;
            xwr_a[i] = '0;
            dv_a[i] = 1'b0;
            for (int e = 0; e < 3; e++) begin
                xain_a[i][e]  = '0;
                xaout_a[i][e] = '0;
            end
            m_lidx[i] = '0;
            m_cnt[i]  = '0;
            m_err[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_eq("reset_busy", busy_a[i], 0);
            chk_eq("reset_done", done_a[i], 0);
            chk_eq("reset_err", err_a[i], 0);
            chk_eq("reset_lidx", lidx_a[i], 0);
            chk_eq("reset_cnt", cnt_a[i], 0);
            chk_eq("reset_x_en", xen_a[i], 0);
            chk_eq("reset_x_dv", xdv_a[i], 0);
            chk_eq("reset_dram_rd", drd_a[i], 0);
            chk_eq("reset_dram_wr", dwr_a[i], 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
        idle(0, 2);

        // Directed run: every layer ends on its 5th RUN cycle, fixed DRAM traffic.
        lens[0] = 5; lens[1] = 5; lens[2] = 5;
        dir29 = 1'b1;
        run_layers(0, 3);
        dir29 = 1'b0;
        chk_eq("final_cnt_15", cnt_a[0], 15);
        chk_eq("final_lidx_2", lidx_a[0], 2);

        rst_mid();

        // Randomized runs with spurious start/done pulses and random DRAM traffic.
        noise_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) lens[k] = $urandom_range(1, 8);
            run_layers(0, 3);
            idle(0, $urandom_range(0, 3));
        end

        // Illegal second layer: sticky error with start ignored.
        idle(1, 2);
        lens[0] = $urandom_range(1, 6);
        run_layers(1, 2);
        idle(1, 10);
        chk_eq("err_sticky", err_a[1], 1);

        // Single layer, then a long layer that saturates the cycle counter.
        idle(2, 2);
        lens[0] = $urandom_range(1, 8);
        run_layers(2, 1);
        lens[0] = 70000;
        run_layers(2, 1);
        chk_eq("cnt_saturated", cnt_a[2], 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
